ds1302_rtc_scheduler: RTL and testbench
=======================================

Name: ds1302_rtc_scheduler

Overview:
Transaction scheduler sitting between the application logic and the existing DS1302 single-byte transfer engine.
- Periodically scans all seven timekeeping registers (sec, min, hour, date, month, day, year) and presents a coherent snapshot.
- Services host "set register" requests by wrapping each write in a write-protect clear and restore sequence.
- Owns the engine's addr/data/valid handshake, so no other logic drives the engine directly.

Parameters:
POLL_PERIOD, 50_000_000, clk cycles between scan starts (1 s at 50 MHz).
BUSY_TIMEOUT, 4_000_000, clk cycles allowed per handshake phase (busy rise, then busy fall) before abort.

Ports:
clk  in  1  system clock
reset_p  in  1  reset
i_enable  in  1  1 = periodic scans allowed
i_set_req  in  1  single-cycle request to write one RTC register
i_set_idx  in  3  register index 0..6 (0 = sec .. 6 = year)
i_set_data  in  8  BCD value to write
o_set_ready  out  1  1 = i_set_req will be accepted this cycle
o_set_ack  out  1  pulse: write sequence completed
o_set_err  out  1  pulse: request rejected (idx > 6) or aborted by timeout
o_sec, o_min, o_hour, o_date, o_month, o_day, o_year  out  8 each  last complete snapshot (raw register bytes)
o_frame_valid  out  1  pulse: snapshot outputs updated this cycle
o_timeout  out  1  pulse: handshake timeout occurred
o_rtc_addr  out  8  to engine i_addr
o_rtc_data  out  8  to engine i_data
o_rtc_valid  out  1  to engine i_valid
i_rtc_busy  in  1  from engine o_busy (slow clock domain)
i_rtc_rdata  in  8  from engine receive byte

Behaviour:
- Reset: reset_p is asynchronous, active-high; clock is clk. All outputs, staging registers, counters and pending flags go to 0; FSM goes to IDLE. Reset mid-transaction drops o_rtc_valid immediately. Nothing is retried.
- Busy sync: i_rtc_busy passes through a 2-flop synchronizer. Rise and fall edges are detected on the synchronized signal.
- Transaction handshake, one byte:
  - ISSUE: drive addr/data, hold o_rtc_valid = 1 until busy rise.
  - WAIT_DONE: valid = 0, wait for busy fall.
  - On a read, capture i_rtc_rdata into staging[step] in the cycle after the fall.
  - addr/data stay stable from ISSUE entry until the busy fall.
- Addresses:
  - Read of register i = 8'h81 + 2*i.
  - Write of register i = 8'h80 + 2*i.
  - WP register: write 8'h8E. o_rtc_data = 8'h00 to clear protection, 8'h80 to set it.
  - o_rtc_data = 0 for all reads.
- FSM states: IDLE, ISSUE, WAIT_DONE, NEXT. A mode bit selects SCAN or WRITE; a 3-bit step counter indexes the sequence.
  - SCAN: steps 0..6, read registers 0..6. After step 6: copy all staging to outputs in one cycle, pulse o_frame_valid, return to IDLE.
  - WRITE: step 0 = WP clear, step 1 = data write to idx, step 2 = WP set. After step 2: pulse o_set_ack, then start a SCAN immediately (readback).
- Poll timer:
  - Free-running 0..POLL_PERIOD-1.
  - At wrap, set poll_pending if i_enable = 1.
  - IDLE starts a SCAN when poll_pending is set, and clears it.
- Set request:
  - o_set_ready = !write_pending.
  - An accepted request with idx <= 6 latches idx/data and sets write_pending.
  - idx > 6: o_set_err pulse, nothing latched.
  - i_set_req while not ready is ignored.
- Priority: write_pending wins over poll_pending in IDLE. The NEXT state of a SCAN also checks write_pending:
  - If set, the scan is abandoned (no frame_valid, outputs unchanged) and the WRITE sequence starts.
  - The post-write SCAN satisfies any pending poll; clear poll_pending.
- Simultaneous events: a poll wrap and a set request in the same cycle set both flags, and the write is serviced first.
- Timeout:
  - Phase counter clears on each ISSUE/WAIT_DONE entry.
  - Reaching BUSY_TIMEOUT triggers: valid low, o_timeout pulse, return to IDLE.
  - An aborted SCAN leaves outputs unchanged.
  - An aborted WRITE pulses o_set_err, clears write_pending, and gets no ack. The WP state of the device is then undefined; the next write re-clears it.
- i_enable low: no new polls latch. An in-progress sequence completes. Writes are still serviced.
- Latency: scan duration is about 7 transactions. The scheduler adds ≤ 3 clk per transaction beyond the engine time plus sync delay.

Decomposition:
- Shared package ds1302_pkg:
  - Address constants: RTC_RD_BASE = 8'h81, RTC_WR_BASE = 8'h80, RTC_WP_ADDR = 8'h8E, WP_CLEAR = 8'h00, WP_SET = 8'h80.
  - NUM_TIME_REGS = 7.
  - State encoding.
- One sub-module: ds1302_busy_sync (2-flop synchronizer plus rise/fall pulse outputs), reusable by other DS1302 clients.

Test Plan:
- Bench: behavioural engine model, busy high for 40 clk, read data = 8'h10 + idx.
- Scan: POLL_PERIOD = 100, i_enable = 1 → addresses 81, 83, 85, 87, 89, 8B, 8D in order; o_frame_valid pulses once; o_sec = 10 … o_year = 16, all updated in the same cycle.
- Write: i_set_req, idx = 2, data = 8'h23 → engine sees writes 8E/00, 84/23, 8E/80; o_set_ack pulses once; a readback scan follows; o_set_ready returns high.
- Preemption: set_req during scan step 3 → step 3 completes; no frame_valid; write sequence runs, then a full scan from addr 81.
- Invalid idx = 7 → o_set_err pulse in the next cycle; no engine activity; o_set_ready stays high.
- Timeout: engine never raises busy, BUSY_TIMEOUT = 50 → o_rtc_valid drops after 50 clk; o_timeout pulses; snapshot outputs unchanged; the next poll retries normally.
- Reset mid-WAIT_DONE → all outputs 0 immediately; after release the first scan starts only at the next poll wrap.

Source files
------------

// File: rtl/ds1302_pkg.sv
// Shared constants, state encoding and transaction helpers for DS1302 clients.
package ds1302_pkg;

  localparam logic [7:0] RTC_RD_BASE = 8'h81;
  localparam logic [7:0] RTC_WR_BASE = 8'h80;
  localparam logic [7:0] RTC_WP_ADDR = 8'h8E;
  localparam logic [7:0] WP_CLEAR    = 8'h00;
  localparam logic [7:0] WP_SET      = 8'h80;

  localparam int NUM_TIME_REGS = 7;
  localparam logic [2:0] SCAN_LAST_STEP = 3'(NUM_TIME_REGS - 1);
  localparam logic [2:0] WR_LAST_STEP   = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_NEXT
  } sched_state_t;

  typedef enum logic {
    MODE_SCAN,
    MODE_WRITE
  } sched_mode_t;

  // Write sequence is WP clear, data write, WP set.
  function automatic logic [7:0] txn_addr(sched_mode_t mode, logic [2:0] step, logic [2:0] idx);
    logic [7:0] addr;
    if (mode == MODE_SCAN) addr = RTC_RD_BASE + {4'd0, step, 1'b0};
    else if (step == 3'd1) addr = RTC_WR_BASE + {4'd0, idx, 1'b0};
    else addr = RTC_WP_ADDR;
    return addr;
  endfunction

  function automatic logic [7:0] txn_data(sched_mode_t mode, logic [2:0] step, logic [7:0] wdata);
    logic [7:0] data;
    if (mode == MODE_SCAN) data = 8'h00;
    else if (step == 3'd0) data = WP_CLEAR;
    else if (step == 3'd1) data = wdata;
    else data = WP_SET;
    return data;
  endfunction

endpackage

// File: rtl/ds1302_busy_sync.sv
// Two-flop synchronizer for the engine busy flag with edge pulses on the
// synchronized level.
module ds1302_busy_sync (
  input  logic clk,
  input  logic reset_p,
  input  logic busy_async,
  output logic busy_rise,
  output logic busy_fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= busy_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign busy_rise = sync_q & ~prev_q;
  assign busy_fall = ~sync_q & prev_q;

endmodule

// File: rtl/ds1302_rtc_scheduler.sv
// Scheduler that owns the DS1302 byte engine: periodic 7-register scans and
// write-protect-wrapped register writes.
//
// state     | meaning
// IDLE      | no transaction; picks write first, then poll
// ISSUE     | addr/data driven, valid high until busy rise
// WAIT_DONE | valid low, waiting for busy fall
// NEXT      | advance step, finish frame/ack or preempt scan
module ds1302_rtc_scheduler
  import ds1302_pkg::*;
#(
  parameter int POLL_PERIOD  = 50_000_000,
  parameter int BUSY_TIMEOUT = 4_000_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       i_enable,
  input  logic       i_set_req,
  input  logic [2:0] i_set_idx,
  input  logic [7:0] i_set_data,
  output logic       o_set_ready,
  output logic       o_set_ack,
  output logic       o_set_err,
  output logic [7:0] o_sec,
  output logic [7:0] o_min,
  output logic [7:0] o_hour,
  output logic [7:0] o_date,
  output logic [7:0] o_month,
  output logic [7:0] o_day,
  output logic [7:0] o_year,
  output logic       o_frame_valid,
  output logic       o_timeout,
  output logic [7:0] o_rtc_addr,
  output logic [7:0] o_rtc_data,
  output logic       o_rtc_valid,
  input  logic       i_rtc_busy,
  input  logic [7:0] i_rtc_rdata
);

  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  sched_state_t state_q, state_d;
  sched_mode_t  mode_q, mode_d;
  logic [2:0]   step_q, step_d;

  logic [PW-1:0] poll_cnt_q;
  logic [TW-1:0] tmr_q;
  logic          poll_wrap, tmr_zero, arm_tmr;
  logic          poll_pending_q, write_pending_q;
  logic [2:0]    wr_idx_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    stage_q [NUM_TIME_REGS];
  logic [7:0]    snap_q  [NUM_TIME_REGS];

  logic busy_rise, busy_fall;
  logic start_txn, cap_rd, frame_upd, ack, abort, clr_poll, clr_write;
  logic accept, idx_ok;

  ds1302_busy_sync u_busy_sync (
    .clk       (clk),
    .reset_p   (reset_p),
    .busy_async(i_rtc_busy),
    .busy_rise (busy_rise),
    .busy_fall (busy_fall)
  );

  assign poll_wrap = (poll_cnt_q == PW'(POLL_PERIOD - 1));
  assign tmr_zero  = (tmr_q == '0);
  assign arm_tmr   = start_txn | ((state_q == ST_ISSUE) & busy_rise);
  assign accept    = i_set_req & ~write_pending_q;
  assign idx_ok    = (i_set_idx < 3'(NUM_TIME_REGS));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    step_d    = step_q;
    start_txn = 1'b0;
    cap_rd    = 1'b0;
    frame_upd = 1'b0;
    ack       = 1'b0;
    abort     = 1'b0;
    clr_poll  = 1'b0;
    clr_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (write_pending_q) begin
          mode_d    = MODE_WRITE;
          step_d    = '0;
          start_txn = 1'b1;
        end else if (poll_pending_q) begin
          mode_d    = MODE_SCAN;
          step_d    = '0;
          start_txn = 1'b1;
          clr_poll  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (busy_rise) state_d = ST_WAIT_DONE;
        else if (tmr_zero) abort = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (busy_fall) begin
          state_d = ST_NEXT;
          cap_rd  = (mode_q == MODE_SCAN);
        end else if (tmr_zero) begin
          abort = 1'b1;
        end
      end
      ST_NEXT: begin
        if (mode_q == MODE_SCAN) begin
          // A pending write abandons the scan; the readback scan replaces it.
          if (write_pending_q) begin
            mode_d    = MODE_WRITE;
            step_d    = '0;
            start_txn = 1'b1;
          end else if (step_q == SCAN_LAST_STEP) begin
            frame_upd = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            step_d    = step_q + 3'd1;
            start_txn = 1'b1;
          end
        end else if (step_q == WR_LAST_STEP) begin
          ack       = 1'b1;
          clr_write = 1'b1;
          clr_poll  = 1'b1;
          mode_d    = MODE_SCAN;
          step_d    = '0;
          start_txn = 1'b1;
        end else begin
          step_d    = step_q + 3'd1;
          start_txn = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_txn) state_d = ST_ISSUE;
    if (abort) begin
      state_d   = ST_IDLE;
      clr_write = (mode_q == MODE_WRITE);
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SCAN;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      tmr_q <= '0;
    end else if (arm_tmr) begin
      tmr_q <= TW'(BUSY_TIMEOUT - 1);
    end else if ((state_q == ST_ISSUE || state_q == ST_WAIT_DONE) && !tmr_zero) begin
      tmr_q <= tmr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      poll_cnt_q     <= '0;
      poll_pending_q <= 1'b0;
    end else begin
      poll_cnt_q <= poll_wrap ? '0 : poll_cnt_q + 1'b1;
      if (poll_wrap && i_enable) poll_pending_q <= 1'b1;
      else if (clr_poll) poll_pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      write_pending_q <= 1'b0;
      wr_idx_q        <= '0;
      wr_data_q       <= '0;
    end else if (accept && idx_ok) begin
      write_pending_q <= 1'b1;
      wr_idx_q        <= i_set_idx;
      wr_data_q       <= i_set_data;
    end else if (clr_write) begin
      write_pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      o_rtc_addr    <= '0;
      o_rtc_data    <= '0;
      o_set_ack     <= 1'b0;
      o_set_err     <= 1'b0;
      o_timeout     <= 1'b0;
      o_frame_valid <= 1'b0;
    end else begin
      if (start_txn) begin
        o_rtc_addr <= txn_addr(mode_d, step_d, wr_idx_q);
        o_rtc_data <= txn_data(mode_d, step_d, wr_data_q);
      end
      o_set_ack     <= ack;
      o_set_err     <= (accept & ~idx_ok) | (abort & (mode_q == MODE_WRITE));
      o_timeout     <= abort;
      o_frame_valid <= frame_upd;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < NUM_TIME_REGS; i++) begin
        stage_q[i] <= '0;
        snap_q[i]  <= '0;
      end
    end else begin
      if (cap_rd) stage_q[step_q] <= i_rtc_rdata;
      if (frame_upd) begin
        for (int i = 0; i < NUM_TIME_REGS; i++) snap_q[i] <= stage_q[i];
      end
    end
  end

  assign o_rtc_valid = (state_q == ST_ISSUE);
  assign o_set_ready = ~write_pending_q;
  assign o_sec   = snap_q[0];
  assign o_min   = snap_q[1];
  assign o_hour  = snap_q[2];
  assign o_date  = snap_q[3];
  assign o_month = snap_q[4];
  assign o_day   = snap_q[5];
  assign o_year  = snap_q[6];

endmodule

// File: tb/tb_ds1302_rtc_scheduler.sv
// Bench for ds1302_rtc_scheduler: a DS1302 register model behind a behavioural
// engine, with frame/ack scoreboarding against the modelled device contents.
module tb_ds1302_rtc_scheduler;

  localparam int POLL = 100;
  localparam int TMO  = 50;

  logic       clk = 1'b0;
  logic       reset_p, i_enable, i_set_req;
  logic [2:0] i_set_idx;
  logic [7:0] i_set_data, i_rtc_rdata;
  logic       i_rtc_busy;
  logic       o_set_ready, o_set_ack, o_set_err, o_frame_valid, o_timeout, o_rtc_valid;
  logic [7:0] o_sec, o_min, o_hour, o_date, o_month, o_day, o_year, o_rtc_addr, o_rtc_data;

  always #5 clk = ~clk;

  ds1302_rtc_scheduler #(.POLL_PERIOD(POLL), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_p(reset_p), .i_enable(i_enable),
    .i_set_req(i_set_req), .i_set_idx(i_set_idx), .i_set_data(i_set_data),
    .o_set_ready(o_set_ready), .o_set_ack(o_set_ack), .o_set_err(o_set_err),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_date(o_date),
    .o_month(o_month), .o_day(o_day), .o_year(o_year),
    .o_frame_valid(o_frame_valid), .o_timeout(o_timeout),
    .o_rtc_addr(o_rtc_addr), .o_rtc_data(o_rtc_data), .o_rtc_valid(o_rtc_valid),
    .i_rtc_busy(i_rtc_busy), .i_rtc_rdata(i_rtc_rdata)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Device model and scoreboard state
  logic [7:0]  rtc_regs [7];
  logic        wp = 1'b1;
  logic [15:0] log_q [$];
  logic [10:0] req_q [$];
  logic [7:0]  last_addr = 8'h00;
  bit eng_dead = 0, busy_rand = 0, expect_rb = 0, model_pending = 0;
  int rst_gen = 0, frame_cnt = 0;

  function automatic logic [55:0] snap();
    return {o_sec, o_min, o_hour, o_date, o_month, o_day, o_year};
  endfunction

  // Engine: busy rises two clocks after valid, stays high for the busy length.
  initial begin
    logic [7:0] a, d;
    int ri, len, g;
    for (int i = 0; i < 7; i++) rtc_regs[i] = 8'h10 + 8'(i);
    i_rtc_busy = 1'b0;
    i_rtc_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (o_rtc_valid && !eng_dead && !reset_p) begin
        a = o_rtc_addr;
        d = o_rtc_data;
        g = rst_gen;
        repeat (2) @(posedge clk);
        #1 i_rtc_busy = 1'b1;
        log_q.push_back({a, d});
        last_addr = a;
        if (expect_rb) begin
          chk("readback_start", a, 8'h81);
          expect_rb = 0;
        end
        if (a[0]) begin
          ri = int'(a - 8'h81) >> 1;
          i_rtc_rdata = (ri < 7) ? rtc_regs[ri] : 8'hEE;
          chk("read_data_zero", d, 8'h00);
        end else if (a == 8'h8E) begin
          wp = d[7];
        end else if (!wp) begin
          ri = int'(a - 8'h80) >> 1;
          if (ri < 7) rtc_regs[ri] = d;
        end
        len = busy_rand ? int'($urandom_range(20, 40)) : 40;
        repeat (len) @(posedge clk);
        #1;
        if (g == rst_gen) chk("addr_data_stable", {o_rtc_addr, o_rtc_data}, {a, d});
        i_rtc_busy = 1'b0;
      end
    end
  end

  // Scoreboard: frames must be the seven reads in order and match the device.
  initial begin
    logic [55:0] got_a, exp_a, exp_v;
    logic [47:0] got3;
    logic [10:0] r;
    int n;
    forever begin
      @(negedge clk);
      if (o_frame_valid) begin
        frame_cnt++;
        got_a = '0; exp_a = '0; exp_v = '0;
        n = log_q.size();
        for (int k = 0; k < 7; k++) begin
          exp_a = {exp_a[47:0], 8'h81 + 8'(2 * k)};
          exp_v = {exp_v[47:0], rtc_regs[k]};
          if (n >= 7) got_a = {got_a[47:0], log_q[n - 7 + k][15:8]};
        end
        chk("frame_addr_order", got_a, exp_a);
        chk("frame_values", snap(), exp_v);
      end
      if (o_set_ack) begin
        chk("ack_expected", req_q.size() != 0, 1);
        if (req_q.size() != 0) begin
          r = req_q.pop_front();
          n = log_q.size();
          got3 = (n >= 3) ? {log_q[n-3], log_q[n-2], log_q[n-1]} : '0;
          chk("write_seq", got3, {16'h8E00, 8'h80 + {4'd0, r[10:8], 1'b0}, r[7:0], 16'h8E80});
          chk("write_reg_value", rtc_regs[r[10:8]], r[7:0]);
        end
        model_pending = 0;
        expect_rb = 1;
        chk("ready_after_ack", o_set_ready, 1);
      end
    end
  end

  task automatic do_req(input logic [2:0] idx, input logic [7:0] data);
    @(posedge clk); #1;
    chk("set_ready", o_set_ready, 1);
    i_set_req = 1'b1; i_set_idx = idx; i_set_data = data;
    @(posedge clk); #1;
    i_set_req = 1'b0;
    if (idx > 3'd6) begin
      chk("set_err_pulse", o_set_err, 1);
      chk("ready_after_err", o_set_ready, 1);
    end else begin
      req_q.push_back({idx, data});
      model_pending = 1;
      chk("ready_low_pending", o_set_ready, 0);
    end
  endtask

  task automatic wait_ack(input int bound);
    for (int i = 0; i < bound && model_pending; i++) @(negedge clk);
    chk("ack_wait", model_pending, 0);
  endtask

  task automatic wait_frame(input int bound);
    int f0 = frame_cnt;
    for (int i = 0; i < bound && frame_cnt == f0; i++) @(negedge clk);
    chk("frame_wait", frame_cnt != f0, 1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, pos, f0, s;
    logic [55:0] snap0;
    reset_p = 1'b1; i_enable = 1'b1; i_set_req = 1'b0; i_set_idx = '0; i_set_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {o_set_ack, o_set_err, o_frame_valid, o_timeout, o_rtc_valid, o_rtc_addr, o_rtc_data}, '0);
    chk("reset_snap", snap(), '0);
    chk("reset_ready", o_set_ready, 1);
    reset_p = 1'b0;

    wait_frame(2000);
    chk("first_sec", o_sec, 8'h10);
    chk("first_hour", o_hour, 8'h12);
    chk("first_year", o_year, 8'h16);

    do_req(3'd2, 8'h23);
    wait_ack(3000);
    wait_frame(2000);
    chk("hour_after_write", o_hour, 8'h23);

    do_req(3'd7, 8'h55);

    // Preempt a scan while step 3 (addr 87) is on the wire.
    last_addr = 8'h00;
    for (int i = 0; i < 3000 && last_addr != 8'h87; i++) @(negedge clk);
    chk("saw_step3", last_addr, 8'h87);
    pos = log_q.size() - 1;
    f0 = frame_cnt;
    do_req(3'd5, 8'h31);
    wait_ack(3000);
    chk("preempt_no_frame", frame_cnt, f0);
    chk("preempt_next_txn", (log_q.size() > pos + 1) ? log_q[pos + 1] : 16'h0, 16'h8E00);
    wait_frame(2000);
    chk("day_after_write", o_day, 8'h31);

    i_enable = 1'b0;
    repeat (1000) @(posedge clk);
    s = log_q.size();
    repeat (600) @(posedge clk);
    chk("no_poll_disabled", log_q.size(), s);
    do_req(3'd6, 8'h25);
    wait_ack(3000);
    wait_frame(2000);
    chk("year_after_write", o_year, 8'h25);
    i_enable = 1'b1;

    // Engine never raises busy: valid must stay up exactly BUSY_TIMEOUT clocks.
    eng_dead = 1;
    for (int i = 0; i < 500 && o_rtc_valid; i++) @(negedge clk);
    for (int i = 0; i < 500 && !o_rtc_valid; i++) @(negedge clk);
    snap0 = snap();
    n = 0;
    while (o_rtc_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_valid_cycles", n, TMO);
    chk("tmo_pulse", o_timeout, 1);
    chk("tmo_snap_kept", snap(), snap0);
    eng_dead = 0;
    wait_frame(3000);

    // Reset while the engine is mid-transfer (scheduler in WAIT_DONE).
    for (int i = 0; i < 1000 && !i_rtc_busy; i++) @(negedge clk);
    repeat (10) @(posedge clk);
    #3 reset_p = 1'b1;
    rst_gen++;
    #1;
    chk("midreset_ctl", {o_set_ack, o_set_err, o_frame_valid, o_timeout, o_rtc_valid, o_rtc_addr, o_rtc_data}, '0);
    chk("midreset_snap", snap(), '0);
    repeat (3) @(posedge clk);
    #1 reset_p = 1'b0;
    n = 0;
    while (!o_rtc_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_poll_after_reset", (n >= POLL && n <= POLL + 3), 1);
    wait_frame(2000);

    busy_rand = 1;
    for (int it = 0; it < 14; it++) begin
      logic [2:0] idx;
      logic [7:0] data;
      repeat ($urandom_range(0, 500)) @(posedge clk);
      idx = 3'($urandom_range(0, 7));
      data = 8'($urandom);
      if (!model_pending) begin
        do_req(idx, data);
        if (idx <= 3'd6) wait_ack(3000);
      end
    end
    wait_frame(3000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
